// File: rtl/uart_arbiter.sv
// Two-master round-robin arbiter in front of a single UART register port.
// Optional abort of unanswered UART accesses when UART_ARB_TIMEOUT_EN is defined.
module uart_arbiter #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_m0_enable,
    input  logic                  i_m0_rw,
    input  logic [DATA_WIDTH-1:0] i_m0_wdata,
    output logic [DATA_WIDTH-1:0] o_m0_rdata,
    output logic                  o_m0_ready,
    input  logic                  i_m1_enable,
    input  logic                  i_m1_rw,
    input  logic [DATA_WIDTH-1:0] i_m1_wdata,
    output logic [DATA_WIDTH-1:0] o_m1_rdata,
    output logic                  o_m1_ready,
    output logic                  o_uart_enable,
    output logic                  o_uart_rw,
    output logic [DATA_WIDTH-1:0] o_uart_wdata,
    input  logic [DATA_WIDTH-1:0] i_uart_rdata,
    input  logic                  i_uart_ready
);

    typedef enum logic [2:0] {
        StIdle,
        StGrant0,
        StGrant1,
        StDone0,
        StDone1
    } state_e;

    state_e                  state_q, state_d;
    logic                    last_q, last_d;
    logic                    uart_en_q, uart_en_d;
    logic                    uart_rw_q, uart_rw_d;
    logic [DATA_WIDTH-1:0]   uart_wdata_q, uart_wdata_d;
    logic [DATA_WIDTH-1:0]   m0_rdata_q, m0_rdata_d;
    logic [DATA_WIDTH-1:0]   m1_rdata_q, m1_rdata_d;
    logic                    m0_ready_q, m0_ready_d;
    logic                    m1_ready_q, m1_ready_d;
    logic                    access_end;
    logic [DATA_WIDTH-1:0]   access_data;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned CntWidth = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                timeout;

    assign timeout     = (cnt_q == CntWidth'(TIMEOUT_CYCLES - 1));
    assign access_end  = i_uart_ready || timeout;
    assign access_data = i_uart_ready ? i_uart_rdata : {DATA_WIDTH{1'b1}};

    // Held at zero in IDLE, which clears it on every grant entry.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StIdle) begin
            cnt_d = '0;
        end else if (state_q == StGrant0 || state_q == StGrant1) begin
            cnt_d = cnt_q + CntWidth'(1);
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign access_end  = i_uart_ready;
    assign access_data = i_uart_rdata;
`endif

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        uart_en_d    = uart_en_q;
        uart_rw_d    = uart_rw_q;
        uart_wdata_d = uart_wdata_q;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        m0_ready_d   = m0_ready_q;
        m1_ready_d   = m1_ready_q;

        unique case (state_q)
            StIdle: begin
                // With both requesting, the master not served last wins.
                if (i_m0_enable && (!i_m1_enable || last_q)) begin
                    state_d      = StGrant0;
                    uart_en_d    = 1'b1;
                    uart_rw_d    = i_m0_rw;
                    uart_wdata_d = i_m0_wdata;
                end else if (i_m1_enable) begin
                    state_d      = StGrant1;
                    uart_en_d    = 1'b1;
                    uart_rw_d    = i_m1_rw;
                    uart_wdata_d = i_m1_wdata;
                end
            end
            StGrant0: begin
                if (access_end) begin
                    state_d    = StDone0;
                    last_d     = 1'b0;
                    uart_en_d  = 1'b0;
                    m0_rdata_d = access_data;
                    m0_ready_d = 1'b1;
                end
            end
            StGrant1: begin
                if (access_end) begin
                    state_d    = StDone1;
                    last_d     = 1'b1;
                    uart_en_d  = 1'b0;
                    m1_rdata_d = access_data;
                    m1_ready_d = 1'b1;
                end
            end
            StDone0: begin
                if (!i_m0_enable) begin
                    state_d    = StIdle;
                    m0_ready_d = 1'b0;
                end
            end
            StDone1: begin
                if (!i_m1_enable) begin
                    state_d    = StIdle;
                    m1_ready_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q      <= StIdle;
            last_q       <= 1'b1;
            uart_en_q    <= 1'b0;
            uart_rw_q    <= 1'b0;
            uart_wdata_q <= '0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
            m0_ready_q   <= 1'b0;
            m1_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            uart_en_q    <= uart_en_d;
            uart_rw_q    <= uart_rw_d;
            uart_wdata_q <= uart_wdata_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
            m0_ready_q   <= m0_ready_d;
            m1_ready_q   <= m1_ready_d;
        end
    end

    assign o_uart_enable = uart_en_q;
    assign o_uart_rw     = uart_rw_q;
    assign o_uart_wdata  = uart_wdata_q;
    assign o_m0_rdata    = m0_rdata_q;
    assign o_m1_rdata    = m1_rdata_q;
    assign o_m0_ready    = m0_ready_q;
    assign o_m1_ready    = m1_ready_q;

endmodule

// File: tb/tb_uart_arbiter.sv
// Bench for uart_arbiter: directed scenarios plus a randomized round-robin run against
// a transaction-level model; the timeout scenario is built only with UART_ARB_TIMEOUT_EN.
module tb_uart_arbiter;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_en, m0_rw, m1_en, m1_rw;
    logic [DW-1:0] m0_wd, m1_wd, m0_rd, m1_rd;
    logic          m0_rdy, m1_rdy;
    logic          uart_en, uart_rw, uart_ready;
    logic [DW-1:0] uart_wd, uart_rdata;

    int            errors = 0;
    int            checks = 0;

    // UART responder controls and its log of completed accesses.
    bit            uart_auto   = 1'b1;
    bit            resp_random = 1'b0;
    int            uart_delay  = 0;
    int            wait_cnt    = 0;
    logic [DW-1:0] resp_val    = '0;
    logic [DW-1:0] resp_q[$];
    logic          log_rw_q[$];
    logic [DW-1:0] log_wd_q[$];

    // Enable-gap monitor state.
    int            gap_viol = 0;
    int            low_cnt  = 0;
    bit            saw_high = 1'b0;
    bit            prev_en  = 1'b0;

    always #5 clk = ~clk;

    uart_arbiter #(
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_m0_enable  (m0_en),
        .i_m0_rw      (m0_rw),
        .i_m0_wdata   (m0_wd),
        .o_m0_rdata   (m0_rd),
        .o_m0_ready   (m0_rdy),
        .i_m1_enable  (m1_en),
        .i_m1_rw      (m1_rw),
        .i_m1_wdata   (m1_wd),
        .o_m1_rdata   (m1_rd),
        .o_m1_ready   (m1_rdy),
        .o_uart_enable(uart_en),
        .o_uart_rw    (uart_rw),
        .o_uart_wdata (uart_wd),
        .i_uart_rdata (uart_rdata),
        .i_uart_ready (uart_ready)
    );

    // UART: answers uart_delay cycles after it first sees enable, for one cycle.
    initial begin
        uart_ready = 1'b0;
        uart_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            uart_ready = 1'b0;
            if (uart_auto && uart_en && !rst) begin
                if (wait_cnt >= uart_delay) begin
                    if (resp_random) resp_val = $urandom;
                    uart_ready = 1'b1;
                    uart_rdata = resp_val;
                    resp_q.push_back(resp_val);
                    log_rw_q.push_back(uart_rw);
                    log_wd_q.push_back(uart_wd);
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Counts enable rising edges preceded by fewer than two low cycles.
    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (rst) begin
                saw_high = 1'b0;
                low_cnt  = 0;
            end else if (uart_en) begin
                if (!prev_en && saw_high && low_cnt < 2) gap_viol++;
                saw_high = 1'b1;
                low_cnt  = 0;
            end else begin
                low_cnt++;
            end
            prev_en = uart_en;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        m0_en = 1'b0; m0_rw = 1'b0; m0_wd = '0;
        m1_en = 1'b0; m1_rw = 1'b0; m1_wd = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic clear_logs();
        resp_q.delete();
        log_rw_q.delete();
        log_wd_q.delete();
    endtask

    // Steps until master m shows ready; cyc = cycles taken or -1 on expiry.
    task automatic wait_ready(input int m, input int limit, output int cyc);
        cyc = -1;
        for (int c = 1; c <= limit; c++) begin
            step();
            if ((m == 0 && m0_rdy) || (m == 1 && m1_rdy)) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (uart_en !== 1'b0) begin errors++; $display("FAIL reset_uart_enable: got %b required 0", uart_en); end
        checks++; if (uart_rw !== 1'b0) begin errors++; $display("FAIL reset_uart_rw: got %b required 0", uart_rw); end
        checks++; if (uart_wd !== '0) begin errors++; $display("FAIL reset_uart_wdata: got %h required 0", uart_wd); end
        checks++; if (m0_rdy !== 1'b0) begin errors++; $display("FAIL reset_m0_ready: got %b required 0", m0_rdy); end
        checks++; if (m1_rdy !== 1'b0) begin errors++; $display("FAIL reset_m1_ready: got %b required 0", m1_rdy); end
        checks++; if (m0_rd !== '0) begin errors++; $display("FAIL reset_m0_rdata: got %h required 0", m0_rd); end
        checks++; if (m1_rd !== '0) begin errors++; $display("FAIL reset_m1_rdata: got %h required 0", m1_rd); end
    endtask

    task automatic test_write();
        int en_cyc = -1;
        int rdy_cyc = -1;
        logic [DW-1:0] wd_first = '0;
        logic [DW-1:0] wd_last = '0;
        logic rw_first = 1'b0;
        bit m1_touched = 1'b0;
        uart_auto = 1'b1; uart_delay = 3; resp_random = 1'b0; resp_val = 32'hDEAD_BEEF;
        m0_en = 1'b1; m0_rw = 1'b1; m0_wd = 32'h41;
        for (int c = 1; c <= 20 && rdy_cyc < 0; c++) begin
            step();
            if (uart_en && en_cyc < 0) begin
                en_cyc = c; wd_first = uart_wd; rw_first = uart_rw;
                m0_wd = 32'h99; m0_rw = 1'b0;
            end
            if (uart_en) wd_last = uart_wd;
            if (m1_rdy || m1_rd !== '0) m1_touched = 1'b1;
            if (m0_rdy) rdy_cyc = c;
        end
        checks++; if (en_cyc !== 1) begin errors++; $display("FAIL write_enable_cycle: got %0d required 1", en_cyc); end
        checks++; if (wd_first !== 32'h41) begin errors++; $display("FAIL write_wdata: got %h required 41", wd_first); end
        checks++; if (rw_first !== 1'b1) begin errors++; $display("FAIL write_rw: got %b required 1", rw_first); end
        checks++; if (wd_last !== 32'h41) begin errors++; $display("FAIL write_wdata_held: got %h required 41", wd_last); end
        checks++; if (rdy_cyc !== 5) begin errors++; $display("FAIL write_ready_cycle: got %0d required 5", rdy_cyc); end
        checks++; if (m1_touched) begin errors++; $display("FAIL write_m1_untouched: got 1 required 0"); end
        step();
        checks++; if (m0_rdy !== 1'b1) begin errors++; $display("FAIL write_ready_hold: got %b required 1", m0_rdy); end
        m0_en = 1'b0;
        step();
        checks++; if (m0_rdy !== 1'b0) begin errors++; $display("FAIL write_ready_drop: got %b required 0", m0_rdy); end
        checks++; if (uart_en !== 1'b0) begin errors++; $display("FAIL write_enable_low: got %b required 0", uart_en); end
    endtask

    task automatic test_read_hold();
        int cyc;
        resp_random = 1'b0; resp_val = 32'h5A; uart_delay = $urandom_range(0, 4);
        m1_en = 1'b1; m1_rw = 1'b0; m1_wd = $urandom;
        wait_ready(1, 30, cyc);
        checks++; if (cyc < 0) begin errors++; $display("FAIL read_done: got timeout required m1 ready"); end
        checks++; if (m1_rd !== 32'h5A) begin errors++; $display("FAIL read_rdata: got %h required 5a", m1_rd); end
        m1_en = 1'b0;
        for (int i = 0; i < 3; i++) step();
        checks++; if (m1_rd !== 32'h5A) begin errors++; $display("FAIL read_rdata_idle: got %h required 5a", m1_rd); end
        resp_val = 32'h77; m0_en = 1'b1; m0_rw = 1'b0;
        wait_ready(0, 30, cyc);
        m0_en = 1'b0;
        step();
        checks++; if (m0_rd !== 32'h77) begin errors++; $display("FAIL read_m0_rdata: got %h required 77", m0_rd); end
        checks++; if (m1_rd !== 32'h5A) begin errors++; $display("FAIL read_rdata_other: got %h required 5a", m1_rd); end
    endtask

    task automatic test_early_drop();
        int pulses = 0;
        bit granted = 1'b0;
        clear_logs();
        resp_random = 1'b1; uart_delay = 2;
        m0_en = 1'b1; m0_rw = 1'b0;
        for (int c = 0; c < 10 && !granted; c++) begin
            step();
            granted = uart_en;
        end
        m0_en = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (m0_rdy) pulses++;
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL early_drop_pulse: got %0d required 1", pulses); end
        checks++;
        if (resp_q.size() != 1) begin
            errors++; $display("FAIL early_drop_access: got %0d required 1", resp_q.size());
        end else if (m0_rd !== resp_q[0]) begin
            errors++; $display("FAIL early_drop_rdata: got %h required %h", m0_rd, resp_q[0]);
        end
    endtask

    task automatic test_both_same();
        int c0, c1;
        logic [DW-1:0] wd0, wd1;
        apply_reset();
        clear_logs();
        resp_random = 1'b1; uart_delay = $urandom_range(0, 3);
        wd0 = $urandom; wd1 = wd0 ^ 32'h1;
        m0_en = 1'b1; m0_rw = 1'b1; m0_wd = wd0;
        m1_en = 1'b1; m1_rw = 1'b1; m1_wd = wd1;
        wait_ready(0, 30, c0);
        m0_en = 1'b0;
        wait_ready(1, 30, c1);
        m1_en = 1'b0;
        step();
        checks++; if (c0 < 0 || c1 < 0) begin errors++; $display("FAIL both_order: got m0=%0d m1=%0d required both served", c0, c1); end
        checks++;
        if (log_wd_q.size() != 2) begin
            errors++; $display("FAIL both_accesses: got %0d required 2", log_wd_q.size());
        end else if (log_wd_q[0] !== wd0 || log_wd_q[1] !== wd1) begin
            errors++; $display("FAIL both_wdata_order: got %h,%h required %h,%h", log_wd_q[0], log_wd_q[1], wd0, wd1);
        end
        checks++; if (gap_viol !== 0) begin errors++; $display("FAIL both_enable_gap: got %0d short gaps required 0", gap_viol); end
    endtask

    // Both masters always requesting: grants must alternate, starting with m0 after reset.
    task automatic test_round_robin();
        int served = 0;
        int expm = 0;
        int got;
        bit relaunch[2] = '{1'b0, 1'b0};
        logic cur_rw[2];
        logic [DW-1:0] cur_wd[2];
        logic [DW-1:0] exp_rd, rd;
        logic exp_rw;
        logic [DW-1:0] exp_wd;
        apply_reset();
        clear_logs();
        resp_random = 1'b1; uart_delay = $urandom_range(0, 4);
        cur_rw[0] = 1'($urandom); cur_wd[0] = $urandom;
        cur_rw[1] = 1'($urandom); cur_wd[1] = $urandom;
        m0_en = 1'b1; m0_rw = cur_rw[0]; m0_wd = cur_wd[0];
        m1_en = 1'b1; m1_rw = cur_rw[1]; m1_wd = cur_wd[1];
        for (int c = 0; c < 600 && served < 12; c++) begin
            step();
            if (relaunch[0]) begin
                cur_rw[0] = 1'($urandom); cur_wd[0] = $urandom;
                m0_en = 1'b1; m0_rw = cur_rw[0]; m0_wd = cur_wd[0]; relaunch[0] = 1'b0;
            end
            if (relaunch[1]) begin
                cur_rw[1] = 1'($urandom); cur_wd[1] = $urandom;
                m1_en = 1'b1; m1_rw = cur_rw[1]; m1_wd = cur_wd[1]; relaunch[1] = 1'b0;
            end
            if (m0_rdy || m1_rdy) begin
                got = m0_rdy ? 0 : 1;
                rd  = m0_rdy ? m0_rd : m1_rd;
                checks++; if (got !== expm) begin errors++; $display("FAIL rr_grant_%0d: got master %0d required %0d", served, got, expm); end
                checks++; if (m0_rdy && m1_rdy) begin errors++; $display("FAIL rr_single_ready_%0d: got both required one", served); end
                checks++;
                if (resp_q.size() == 0) begin
                    errors++; $display("FAIL rr_access_%0d: got no UART access required one", served);
                end else begin
                    exp_rd = resp_q.pop_front();
                    exp_rw = log_rw_q.pop_front();
                    exp_wd = log_wd_q.pop_front();
                    if (rd !== exp_rd) begin errors++; $display("FAIL rr_rdata_%0d: got %h required %h", served, rd, exp_rd); end
                    checks++; if (exp_rw !== cur_rw[got]) begin errors++; $display("FAIL rr_rw_%0d: got %b required %b", served, exp_rw, cur_rw[got]); end
                    checks++; if (exp_wd !== cur_wd[got]) begin errors++; $display("FAIL rr_wdata_%0d: got %h required %h", served, exp_wd, cur_wd[got]); end
                end
                if (got == 0) m0_en = 1'b0; else m1_en = 1'b0;
                relaunch[got] = 1'b1;
                expm = 1 - got;
                served++;
                uart_delay = $urandom_range(0, 4);
            end
        end
        m0_en = 1'b0; m1_en = 1'b0;
        step(); step();
        checks++; if (served !== 12) begin errors++; $display("FAIL rr_served: got %0d required 12", served); end
        checks++; if (gap_viol !== 0) begin errors++; $display("FAIL rr_enable_gap: got %0d short gaps required 0", gap_viol); end
    endtask

    task automatic test_reset_mid();
        bit granted = 1'b0;
        bit seen = 1'b0;
        apply_reset();
        uart_auto = 1'b0;
        m1_en = 1'b1; m1_rw = 1'b1; m1_wd = 32'hCAFE_F00D;
        for (int c = 0; c < 10 && !granted; c++) begin
            step();
            granted = uart_en;
        end
        checks++; if (!granted) begin errors++; $display("FAIL rst_mid_grant: got no grant required GRANT1"); end
        rst = 1'b1;
        step();
        rst = 1'b0; m1_en = 1'b0;
        checks++; if (uart_en !== 1'b0) begin errors++; $display("FAIL rst_mid_enable: got %b required 0", uart_en); end
        checks++; if (m1_rdy !== 1'b0) begin errors++; $display("FAIL rst_mid_m1_ready: got %b required 0", m1_rdy); end
        checks++;
        if ({uart_rw, uart_wd, m0_rd, m1_rd, m0_rdy} !== '0) begin
            errors++; $display("FAIL rst_mid_outputs: got rw=%b wd=%h rd0=%h rd1=%h rdy0=%b required all 0",
                               uart_rw, uart_wd, m0_rd, m1_rd, m0_rdy);
        end
        for (int c = 0; c < 5; c++) begin
            step();
            if (m1_rdy || uart_en) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL rst_mid_quiet: got activity required none"); end
        uart_auto = 1'b1;
    endtask

`ifdef UART_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int cyc;
        apply_reset();
        uart_auto = 1'b0;
        m0_en = 1'b1; m0_rw = 1'b0;
        wait_ready(0, 40, cyc);
        checks++; if (cyc !== 17) begin errors++; $display("FAIL timeout_cycle: got %0d required 17", cyc); end
        checks++; if (m0_rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL timeout_rdata: got %h required ffffffff", m0_rd); end
        m0_en = 1'b0;
        step();
        uart_auto = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read_hold();
        test_early_drop();
        test_both_same();
        test_round_robin();
        test_reset_mid();
`ifdef UART_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
